imem_fetch_ctrl: RTL and testbench

- Fetch sequencer between the core's PC/redirect logic and the byte-addressed, combinational-read instruction memory.
- Waits for the memory's load-complete flag, then issues sequential word addresses and captures returned instructions with their PC.
- Captured instructions go into a small FIFO and are handed to decode over a valid/ready handshake.
- Handles branch/jump redirects, back-pressure from decode and a halt-on-ECALL stop condition.

---
 rtl/imem_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: waits for the memory image, streams sequential words into a small FIFO
// for decode, and handles redirects, back-pressure and ECALL halt. Optional counter: FETCH_COUNT_EN.
module imem_fetch_ctrl #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [31:0]     HALT_INST  = 32'h00000073
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_done_load_inst,
  output logic [XLEN-1:0] out_inst_addr,
  input  logic [31:0]     in_inst,
  input  logic            in_redirect_valid,
  input  logic [XLEN-1:0] in_redirect_pc,
  output logic            out_valid,
  input  logic            in_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_halted,
  output logic            out_misaligned,
  output logic [63:0]     out_fetch_count,
  output logic [1:0]      dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_WAIT_LOAD = 2'd0,
    S_FETCH     = 2'd1,
    S_HALT      = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [31:0]     inst_mem [FIFO_DEPTH];
  logic            misaligned_q;

  logic fifo_empty, fifo_full, pop, push, is_halt, redir_mis;

  // Handshake: decode takes the head on any edge where out_valid && in_ready; out_valid depends
  // only on registered FIFO state, never on in_ready.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = out_valid && in_ready;
  assign push       = (state_q == S_FETCH) && !in_redirect_valid && (!fifo_full || pop);
  assign is_halt    = (in_inst == HALT_INST);
  assign redir_mis  = in_redirect_valid && (in_redirect_pc[1:0] != 2'b00);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAIT_LOAD;
    else        state_q <= state_d;
  end

  // FSM next state; a redirect overrides everything else
  always_comb begin
    state_d = state_q;
    if (in_redirect_valid) begin
      if (redir_mis)                state_d = S_HALT;
      else if (state_q == S_HALT)   state_d = S_FETCH;
    end else begin
      case (state_q)
        S_WAIT_LOAD: if (in_done_load_inst) state_d = S_FETCH;
        S_FETCH:     if (push && is_halt)   state_d = S_HALT;
        default:     state_d = state_q;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    out_valid  = !fifo_empty;
    out_halted = (state_q == S_HALT);
    dbg_state  = state_q;
  end

  // Fetch PC holds on the halt word so a later inspection shows where fetching stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      if (in_redirect_valid)     pc_q <= in_redirect_pc;
      else if (push && !is_halt) pc_q <= pc_q + XLEN'(4);
      if (redir_mis) misaligned_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (in_redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible once the pointers say so
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q[AW-1:0]]   <= pc_q;
      inst_mem[wr_ptr_q[AW-1:0]] <= in_inst;
    end
  end

  assign out_inst_addr  = pc_q;
  assign out_pc         = pc_mem[rd_ptr_q[AW-1:0]];
  assign out_inst       = inst_mem[rd_ptr_q[AW-1:0]];
  assign out_misaligned = misaligned_q;

`ifdef FETCH_COUNT_EN
  logic [63:0] fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   fetch_count_q <= '0;
    else if (pop) fetch_count_q <= fetch_count_q + 64'd1;
  end

  assign out_fetch_count = fetch_count_q;
`else
  assign out_fetch_count = 64'd0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a vector table for streaming/back-pressure/redirect,
// plus hand sequences for halt, misaligned redirect, async reset, wait-load redirect, wrap and count.
module tb_imem_fetch_ctrl;

  logic        clk, rst_n, done_load, redirect_valid, ready;
  logic [63:0] inst_addr, redirect_pc, pc, fetch_count;
  logic [31:0] inst, mem_inst;
  logic        valid, halted, misaligned;
  logic [1:0]  state;

  logic        halt_en;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];

  imem_fetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_done_load_inst (done_load),
    .out_inst_addr     (inst_addr),
    .in_inst           (mem_inst),
    .in_redirect_valid (redirect_valid),
    .in_redirect_pc    (redirect_pc),
    .out_valid         (valid),
    .in_ready          (ready),
    .out_pc            (pc),
    .out_inst          (inst),
    .out_halted        (halted),
    .out_misaligned    (misaligned),
    .out_fetch_count   (fetch_count),
    .dbg_state         (state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // memory model: word index of the address, with an optional ECALL at 0x10
  always_comb begin
    mem_inst = inst_addr[33:2];
    if (halt_en && inst_addr == 64'h10) mem_inst = 32'h00000073;
  end

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        ev;
    logic [63:0] epc;
    logic [31:0] einst;
    logic [63:0] eaddr;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: consume n deliveries, checking each against the expected pc queue
  task automatic take(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    logic [63:0] e;
    while (got < n && cyc < budget) begin
      if (valid && ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
        chk("take_pc", pc, e);
        chk("take_inst", {32'd0, inst}, {32'd0, e[33:2]});
        got++;
      end
      tick();
      cyc++;
    end
    if (got < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL take_timeout: got %0d deliveries expected %0d", got, n);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  64'h0};
    vecs[1]  = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h0,   32'h0,  64'h4};
    vecs[2]  = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h4,   32'h1,  64'h8};
    vecs[3]  = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h8,   32'h2,  64'hC};
    vecs[4]  = '{1'b0, 64'h0,   1'b0, 1'b1, 64'hC,   32'h3,  64'h10};
    vecs[5]  = '{1'b0, 64'h0,   1'b0, 1'b1, 64'hC,   32'h3,  64'h14};
    vecs[6]  = '{1'b0, 64'h0,   1'b0, 1'b1, 64'hC,   32'h3,  64'h14};
    vecs[7]  = '{1'b0, 64'h0,   1'b0, 1'b1, 64'hC,   32'h3,  64'h14};
    vecs[8]  = '{1'b0, 64'h0,   1'b0, 1'b1, 64'hC,   32'h3,  64'h14};
    vecs[9]  = '{1'b0, 64'h0,   1'b1, 1'b1, 64'hC,   32'h3,  64'h14};
    vecs[10] = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h10,  32'h4,  64'h18};
    vecs[11] = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h14,  32'h5,  64'h1C};
    vecs[12] = '{1'b1, 64'h100, 1'b1, 1'b1, 64'h18,  32'h6,  64'h20};
    vecs[13] = '{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  64'h100};
    vecs[14] = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h100, 32'h40, 64'h104};
    vecs[15] = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h104, 32'h41, 64'h108};

    rst_n = 1'b0; done_load = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ready = 1'b1; halt_en = 1'b0;
    tick(); tick();
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_misaligned", {63'd0, misaligned}, 64'd0);
    chk("rst_count", fetch_count, 64'd0);
    chk("rst_addr", inst_addr, 64'h0);
    chk("rst_state", {62'd0, state}, 64'd0);
    rst_n = 1'b1;

    // no deliveries while the memory image is loading
    for (int i = 0; i < 10; i++) begin
      chk("wait_valid", {63'd0, valid}, 64'd0);
      chk("wait_addr", inst_addr, 64'h0);
      tick();
    end
    done_load = 1'b1;
    tick();

    // streaming, back-pressure with full FIFO, and a flushing redirect
    for (int i = 0; i < 16; i++) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      ready          = vecs[i].rdy;
      chk($sformatf("vec%0d_valid", i), {63'd0, valid}, {63'd0, vecs[i].ev});
      chk($sformatf("vec%0d_addr", i), inst_addr, vecs[i].eaddr);
      chk($sformatf("vec%0d_halted", i), {63'd0, halted}, 64'd0);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_pc", i), pc, vecs[i].epc);
        chk($sformatf("vec%0d_inst", i), {32'd0, inst}, {32'd0, vecs[i].einst});
      end
      tick();
    end
    redirect_valid = 1'b0;
    ready = 1'b1;

    // halt on ECALL at 0x10, then redirect resumes fetching
    rst_n = 1'b0; halt_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_seq_valid", {63'd0, valid}, 64'd1);
      chk("halt_seq_pc", pc, 64'(4 * i));
      chk("halt_seq_inst", {32'd0, inst}, (i == 4) ? 64'h73 : 64'(i));
      chk("halt_seq_halted", {63'd0, halted}, (i == 4) ? 64'd1 : 64'd0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halted_valid", {63'd0, valid}, 64'd0);
      chk("halted_flag", {63'd0, halted}, 64'd1);
      chk("halted_addr", inst_addr, 64'h10);
    end
    chk("halted_state", {62'd0, state}, 64'd2);
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect_valid = 1'b0;
    chk("resume_halted", {63'd0, halted}, 64'd0);
    chk("resume_addr", inst_addr, 64'h40);
    chk("resume_valid", {63'd0, valid}, 64'd0);
    tick();
    chk("resume_pc0", pc, 64'h40);
    chk("resume_inst0", {32'd0, inst}, 64'h10);
    tick();
    chk("resume_pc1", pc, 64'h44);
    chk("resume_inst1", {32'd0, inst}, 64'h11);

    // misaligned redirect target halts and sets the sticky flag
    redirect_valid = 1'b1; redirect_pc = 64'h102;
    tick();
    redirect_valid = 1'b0;
    chk("mis_flag", {63'd0, misaligned}, 64'd1);
    chk("mis_halted", {63'd0, halted}, 64'd1);
    chk("mis_addr", inst_addr, 64'h102);
    for (int i = 0; i < 3; i++) begin
      chk("mis_valid", {63'd0, valid}, 64'd0);
      tick();
    end
    chk("mis_sticky", {63'd0, misaligned}, 64'd1);

    // asynchronous reset in the middle of a cycle
    #3;
    rst_n = 1'b0; done_load = 1'b0; halt_en = 1'b0;
    #1;
    chk("arst_misaligned", {63'd0, misaligned}, 64'd0);
    chk("arst_halted", {63'd0, halted}, 64'd0);
    chk("arst_valid", {63'd0, valid}, 64'd0);
    chk("arst_addr", inst_addr, 64'h0);
    chk("arst_count", fetch_count, 64'd0);
    tick();
    rst_n = 1'b1;

    // redirect while still loading keeps the new PC
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    tick();
    redirect_valid = 1'b0;
    chk("wl_addr", inst_addr, 64'h200);
    chk("wl_valid", {63'd0, valid}, 64'd0);
    chk("wl_state", {62'd0, state}, 64'd0);
    tick();
    chk("wl_addr_hold", inst_addr, 64'h200);
    chk("wl_valid_hold", {63'd0, valid}, 64'd0);
    done_load = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back(64'h200 + 64'(4 * i));
    take(7, 40);

    // redirect with no pop in flight, near the top of the address space to exercise wrap
    ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0; ready = 1'b1;
    chk("wrap_addr", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    take(3, 40);
    chk("wrap_misaligned", {63'd0, misaligned}, 64'd0);
`ifdef FETCH_COUNT_EN
    chk("fetch_count", fetch_count, 64'd10);
`else
    chk("fetch_count", fetch_count, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
